// File: rtl/mcb_cmd_dispatcher.sv
// mcb_cmd_dispatcher: queues decoded SPI commands and issues them one at a time to the
// camwrite / read / mem targets. Define MCB_DISPATCH_TIMEOUT_EN to enable the WAIT timeout and abort.
module mcb_cmd_dispatcher #(
  parameter int              FIFO_DEPTH     = 4,
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                          sysClk,
  input  logic                          sysRst_n,
  input  logic [7:0]                    instruction,
  input  logic [63:0]                   data,
  input  logic                          valid_camwrite,
  input  logic                          valid_read,
  input  logic                          valid_mem,
  input  logic                          camwrite_done,
  input  logic                          read_done,
  input  logic                          mem_done,
  input  logic                          err_clear,
  output logic [7:0]                    disp_instr,
  output logic [63:0]                   disp_data,
  output logic [1:0]                    disp_target,
  output logic                          camwrite_start,
  output logic                          read_start,
  output logic                          mem_start,
  output logic                          camwrite_abort,
  output logic                          read_abort,
  output logic                          mem_abort,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count,
  output logic                          overflow_flag,
  output logic                          conflict_flag,
  output logic                          timeout_flag,
  output logic [7:0]                    timeout_instr,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 74;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] TGT_CAM  = 2'd0;
  localparam logic [1:0] TGT_READ = 2'd1;
  localparam logic [1:0] TGT_MEM  = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES == '0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]    state;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic [1:0]    push_tgt;
  logic          push_req;
  logic          conflict;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          sel_done;
  logic          timeout_evt;

  assign fsm_state = state;

  // Handshake: strobes and done pulses are single-cycle qualifiers with no ready/backpressure;
  // a strobe that cannot be queued is dropped and reported through overflow_flag.
  always_comb begin
    push_tgt = TGT_MEM;
    if (valid_camwrite)  push_tgt = TGT_CAM;
    else if (valid_read) push_tgt = TGT_READ;
  end

  assign push_req = valid_camwrite | valid_read | valid_mem;
  assign conflict = (valid_camwrite & valid_read) | (valid_camwrite & valid_mem) |
                    (valid_read & valid_mem);
  assign full     = (queue_count == FULL_CNT);
  assign pop      = (state == ST_IDLE) && (queue_count != '0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign head     = fifo_mem[rd_ptr];

  always_comb begin
    sel_done = 1'b0;
    case (disp_target)
      TGT_CAM:  sel_done = camwrite_done;
      TGT_READ: sel_done = read_done;
      TGT_MEM:  sel_done = mem_done;
      default:  sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (push) fifo_mem[wr_ptr] <= {push_tgt, instruction, data};
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + CNT_ONE;
        2'b01:   queue_count <= queue_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Start pulses are registered at the pop edge so they coincide with the ISSUE cycle.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      disp_instr     <= '0;
      disp_data      <= '0;
      disp_target    <= TGT_CAM;
      camwrite_start <= 1'b0;
      read_start     <= 1'b0;
      mem_start      <= 1'b0;
    end else begin
      camwrite_start <= 1'b0;
      read_start     <= 1'b0;
      mem_start      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            disp_target    <= head[73:72];
            disp_instr     <= head[71:64];
            disp_data      <= head[63:0];
            camwrite_start <= (head[73:72] == TGT_CAM);
            read_start     <= (head[73:72] == TGT_READ);
            mem_start      <= (head[73:72] == TGT_MEM);
            busy           <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (sel_done || timeout_evt) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      overflow_flag <= 1'b0;
      conflict_flag <= 1'b0;
    end else begin
      if (drop)           overflow_flag <= 1'b1;
      else if (err_clear) overflow_flag <= 1'b0;
      if (conflict)       conflict_flag <= 1'b1;
      else if (err_clear) conflict_flag <= 1'b0;
    end
  end

`ifdef MCB_DISPATCH_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_W'(1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt;

  // A done arriving in the last WAIT cycle takes precedence over the timeout.
  assign timeout_evt = (state == ST_WAIT) && !sel_done && (to_cnt == TO_LAST);

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      to_cnt         <= '0;
      camwrite_abort <= 1'b0;
      read_abort     <= 1'b0;
      mem_abort      <= 1'b0;
      timeout_flag   <= 1'b0;
      timeout_instr  <= '0;
    end else begin
      camwrite_abort <= timeout_evt && (disp_target == TGT_CAM);
      read_abort     <= timeout_evt && (disp_target == TGT_READ);
      mem_abort      <= timeout_evt && (disp_target == TGT_MEM);
      if (state == ST_ISSUE)     to_cnt <= '0;
      else if (state == ST_WAIT) to_cnt <= to_cnt + TO_ONE;
      if (timeout_evt) begin
        timeout_flag  <= 1'b1;
        timeout_instr <= disp_instr;
      end else if (err_clear) begin
        timeout_flag <= 1'b0;
      end
    end
  end
`else
  assign timeout_evt    = 1'b0;
  assign camwrite_abort = 1'b0;
  assign read_abort     = 1'b0;
  assign mem_abort      = 1'b0;
  assign timeout_flag   = 1'b0;
  assign timeout_instr  = 8'h00;
`endif

endmodule

// File: tb/tb_mcb_cmd_dispatcher.sv
// Directed bench for mcb_cmd_dispatcher: issue timing, queueing, overflow, conflict,
// target-selective done, timeout/abort (when enabled) and asynchronous reset.
module tb_mcb_cmd_dispatcher;

  logic        sysClk;
  logic        sysRst_n;
  logic [7:0]  instruction;
  logic [63:0] data;
  logic        valid_camwrite, valid_read, valid_mem;
  logic        camwrite_done, read_done, mem_done;
  logic        err_clear;
  logic [7:0]  disp_instr;
  logic [63:0] disp_data;
  logic [1:0]  disp_target;
  logic        camwrite_start, read_start, mem_start;
  logic        camwrite_abort, read_abort, mem_abort;
  logic        busy;
  logic [2:0]  queue_count;
  logic        overflow_flag, conflict_flag, timeout_flag;
  logic [7:0]  timeout_instr;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int start_seen;
  int abort_seen;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  mcb_cmd_dispatcher #(
    .FIFO_DEPTH     (4),
    .TO_W           (24),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .sysClk         (sysClk),
    .sysRst_n       (sysRst_n),
    .instruction    (instruction),
    .data           (data),
    .valid_camwrite (valid_camwrite),
    .valid_read     (valid_read),
    .valid_mem      (valid_mem),
    .camwrite_done  (camwrite_done),
    .read_done      (read_done),
    .mem_done       (mem_done),
    .err_clear      (err_clear),
    .disp_instr     (disp_instr),
    .disp_data      (disp_data),
    .disp_target    (disp_target),
    .camwrite_start (camwrite_start),
    .read_start     (read_start),
    .mem_start      (mem_start),
    .camwrite_abort (camwrite_abort),
    .read_abort     (read_abort),
    .mem_abort      (mem_abort),
    .busy           (busy),
    .queue_count    (queue_count),
    .overflow_flag  (overflow_flag),
    .conflict_flag  (conflict_flag),
    .timeout_flag   (timeout_flag),
    .timeout_instr  (timeout_instr),
    .fsm_state      (fsm_state)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v = {camwrite, read, mem}; strobe lasts exactly one cycle
  task automatic push(input logic [2:0] v, input logic [7:0] ins, input logic [63:0] d);
    {valid_camwrite, valid_read, valid_mem} = v;
    instruction = ins;
    data        = d;
    tick();
    {valid_camwrite, valid_read, valid_mem} = 3'b000;
  endtask

  initial begin
    sysRst_n = 1'b0;
    instruction = '0;
    data = '0;
    {valid_camwrite, valid_read, valid_mem} = 3'b000;
    {camwrite_done, read_done, mem_done} = 3'b000;
    err_clear = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_qcount", queue_count, 0);
    chk("rst_starts", {camwrite_start, read_start, mem_start}, 0);
    chk("rst_flags", {overflow_flag, conflict_flag, timeout_flag}, 0);
    chk("rst_disp", {disp_target, disp_instr}, 0);
    sysRst_n = 1'b1;
    tick();

    // single read: start in cycle N+2
    push(3'b010, 8'h12, 64'hA5);
    chk("rd_q_n1", queue_count, 1);
    chk("rd_nostart_n1", read_start, 0);
    tick();
    chk("rd_start_n2", read_start, 1);
    chk("rd_busy_n2", busy, 1);
    chk("rd_target", disp_target, 1);
    chk("rd_instr", disp_instr, 8'h12);
    chk("rd_data", disp_data, 64'hA5);
    chk("rd_state_issue", fsm_state, S_ISSUE);
    chk("rd_q_n2", queue_count, 0);
    tick();
    chk("rd_start_pulse", read_start, 0);
    chk("rd_state_wait", fsm_state, S_WAIT);
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    chk("rd_done_idle", fsm_state, S_IDLE);
    chk("rd_done_busy", busy, 0);
    chk("rd_hold_instr", disp_instr, 8'h12);

    // camwrite in WAIT: foreign done ignored, then overflow
    push(3'b100, 8'h21, 64'h1111);
    tick();
    chk("cw_start", camwrite_start, 1);
    chk("cw_target", disp_target, 0);
    tick();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    chk("cw_ign_read_done", fsm_state, S_WAIT);
    chk("cw_ign_busy", busy, 1);
    for (int i = 0; i < 5; i++) push(3'b001, 8'h30 + 8'(i), 64'(i));
    chk("ovf_qcount", queue_count, 4);
    chk("ovf_flag", overflow_flag, 1);
    chk("ovf_no_conflict", conflict_flag, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovf_clear", overflow_flag, 0);
    camwrite_done = 1'b1;
    tick();
    camwrite_done = 1'b0;
    chk("b2b_idle", fsm_state, S_IDLE);
    chk("b2b_no_early_start", mem_start, 0);
    tick();
    chk("b2b_mem_start", mem_start, 1);
    chk("b2b_instr", disp_instr, 8'h30);
    chk("b2b_target", disp_target, 2);
    chk("b2b_qcount", queue_count, 3);
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    chk("b2b_second_instr", disp_instr, 8'h31);
    chk("b2b_second_q", queue_count, 2);
    tick();
    chk("pre_rst_wait", fsm_state, S_WAIT);

    // asynchronous reset mid-WAIT with two queued
    #2 sysRst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_state", fsm_state, S_IDLE);
    chk("arst_qcount", queue_count, 0);
    chk("arst_disp", {disp_target, disp_instr}, 0);
    chk("arst_data", disp_data, 0);
    tick();
    tick();
    sysRst_n = 1'b1;
    start_seen = 0;
    repeat (6) begin
      tick();
      if (camwrite_start | read_start | mem_start) start_seen++;
    end
    chk("arst_no_starts", start_seen, 0);
    chk("arst_q_after", queue_count, 0);

    // conflict: camwrite wins over mem
    push(3'b101, 8'h40, 64'h4040);
    chk("cf_qcount", queue_count, 1);
    chk("cf_flag", conflict_flag, 1);
    tick();
    chk("cf_cw_start", camwrite_start, 1);
    chk("cf_no_mem_start", mem_start, 0);
    chk("cf_instr", disp_instr, 8'h40);
    chk("cf_q_after_pop", queue_count, 0);
    tick();
    // set beats clear in the same cycle; read beats mem
    err_clear = 1'b1;
    push(3'b011, 8'h41, 64'h4141);
    err_clear = 1'b0;
    chk("cf_set_wins", conflict_flag, 1);
    chk("cf_q2", queue_count, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("cf_clear", conflict_flag, 0);
    camwrite_done = 1'b1;
    tick();
    camwrite_done = 1'b0;
    tick();
    chk("cf_read_start", read_start, 1);
    chk("cf_read_instr", disp_instr, 8'h41);
    tick();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    chk("cf_read_idle", fsm_state, S_IDLE);

    // mem command with no done, camwrite queued behind it
    push(3'b001, 8'h5A, 64'h5A5A);
    push(3'b100, 8'h5B, 64'h5B5B);
    chk("to_mem_start", mem_start, 1);
    chk("to_qcount", queue_count, 1);
    abort_seen = 0;
    repeat (16) begin
      tick();
      if (camwrite_abort | read_abort | mem_abort) abort_seen++;
    end
    chk("to_no_early_abort", abort_seen, 0);
    chk("to_last_wait", fsm_state, S_WAIT);
    tick();
`ifdef MCB_DISPATCH_TIMEOUT_EN
    chk("to_mem_abort", mem_abort, 1);
    chk("to_other_abort", {camwrite_abort, read_abort}, 0);
    chk("to_state_idle", fsm_state, S_IDLE);
    chk("to_busy", busy, 0);
    chk("to_flag", timeout_flag, 1);
    chk("to_instr", timeout_instr, 8'h5A);
    chk("to_no_start_yet", camwrite_start, 0);
    tick();
    chk("to_abort_pulse", mem_abort, 0);
    chk("to_next_start", camwrite_start, 1);
    chk("to_next_instr", disp_instr, 8'h5B);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_flag_clear", timeout_flag, 0);
    repeat (15) tick();
    camwrite_done = 1'b1;
    tick();
    camwrite_done = 1'b0;
    chk("to_done_wins_state", fsm_state, S_IDLE);
    chk("to_done_wins_abort", camwrite_abort, 0);
    chk("to_done_wins_flag", timeout_flag, 0);
    chk("to_instr_kept", timeout_instr, 8'h5A);
    tick();
    chk("to_no_late_abort", camwrite_abort, 0);
`else
    chk("nto_no_abort", mem_abort, 0);
    chk("nto_still_wait", fsm_state, S_WAIT);
    chk("nto_busy", busy, 1);
    chk("nto_flag", timeout_flag, 0);
    chk("nto_instr", timeout_instr, 0);
    chk("nto_no_start", camwrite_start, 0);
    abort_seen = 0;
    repeat (20) begin
      tick();
      if (camwrite_abort | read_abort | mem_abort) abort_seen++;
    end
    chk("nto_never_abort", abort_seen, 0);
    chk("nto_wait_forever", fsm_state, S_WAIT);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("nto_done_idle", fsm_state, S_IDLE);
    tick();
    chk("nto_next_start", camwrite_start, 1);
    chk("nto_next_instr", disp_instr, 8'h5B);
    tick();
    camwrite_done = 1'b1;
    tick();
    camwrite_done = 1'b0;
    chk("nto_final_idle", fsm_state, S_IDLE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
